alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream stage of the N-bit arithmetic unit. Captures its `out`/`cout` result together with the `select` that produced it, and derives status flags.
- Buffers results in a 2-entry FIFO and presents them to the next consumer over a valid/ready handshake.
- Decouples the combinational ALU from a stalling consumer; rejects and counts the unused select code (3, high-impedance result).

Parameters:
- N, 4, data width; must match the arithmetic unit width.
- DROP_W, 8, width of the dropped-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept a result
- in_result  input  N  arithmetic unit `out`
- in_cout  input  1  arithmetic unit `cout`
- in_select  input  2  operation code that produced in_result (0 add, 1 sub, 2 shift, 3 unused)
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head entry
- out_result  output  N  head entry result
- out_select  output  2  head entry operation code
- out_zero  output  1  head entry result == 0
- out_neg  output  1  head entry result[N-1]
- out_carry  output  1  head entry carry/borrow flag
- op_err  output  1  one-cycle pulse: select-3 beat was consumed and dropped
- drop_count  output  DROP_W  number of dropped select-3 beats, saturating

Behaviour:
- Reset (async, rst=1): FIFO count=0, read/write pointers=0, out_valid=0, in_ready=1, op_err=0, drop_count=0. out_result, out_select and flags read 0 while empty.
- Reset mid-operation: discards all buffered entries immediately; there is no partial output after release.
- Handshakes:
  - Accept on a clk edge with in_valid && in_ready.
  - Pop on a clk edge with out_valid && out_ready.
  - in_ready = (count != 2). It is a function of registered state only and never depends on out_ready.
  - out_valid = (count != 0).
- Latency: an accepted beat appears on out_* at the next edge (1 cycle), provided the FIFO was empty.
- Flags are computed at capture time and stored with the entry:
  - zero = (in_result == 0).
  - neg = in_result[N-1].
  - carry = in_cout for select 0/1; carry = 0 for select 2.
- Select 3:
  - Beat is accepted (honours in_ready) but not written.
  - op_err pulses high for exactly the cycle after acceptance.
  - drop_count increments by 1 and saturates at 2^DROP_W-1 (no wrap).
  - Count is unchanged by the drop itself.
- Simultaneous accept and pop:
  - count=1: count stays 1; the new entry becomes head on the next cycle.
  - count=2: in_ready=0, so pop only.
  - count=0: pop is impossible.
- Pointers are 1 bit and wrap 1→0. Entry order is strict FIFO.
- out_* hold stable while out_valid && !out_ready.
- Inputs are sampled only on accept; X/Z on in_result is ignored when not accepted or when select=3.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- When defined:
  - Each entry stores an extra bit, parity = XOR of in_result (even parity), computed at capture.
  - Exposed on output port out_parity (1 bit), 0 at reset/empty.
- When undefined: port out_parity and the storage bit are absent; all other behaviour is identical.

Test Plan:
- Reset, then N=4, select=0, in_result=4'b0000, in_cout=1, in_valid 1 cycle, out_ready=1 → next cycle out_valid=1, out_zero=1, out_carry=1, out_neg=0; following cycle out_valid=0.
- out_ready=0; push 4'h9/sel1/cout0, 4'h3/sel2/cout1, 4'h5/sel0 → first two accepted, in_ready=0 after second; third held. Raise out_ready → outputs 9 (neg=1, carry=0), then 3 (carry=0), then 5 in order.
- count=1 with simultaneous push 4'h7 and pop → in_ready stays 1, count stays 1, next head=7, no loss or duplication.
- Push select=3 beats 260 times, DROP_W=8 → out_valid never asserts, op_err pulses once per beat, drop_count saturates at 255.
- Fill FIFO to 2, assert rst asynchronously mid-cycle → out_valid=0 and in_ready=1 immediately, before the next edge; drop_count=0.
- With ALU_RESULT_PARITY_EN: push 4'b1011 → out_parity=1; push 4'b0110 → out_parity=0.

Source files
------------

// File: rtl/alu_result_stage.sv
// Result stage behind the N-bit arithmetic unit: flags each result, buffers it in a 2-entry FIFO
// and hands it on over valid/ready. Optional per-entry even parity via `define ALU_RESULT_PARITY_EN.
module alu_result_stage #(
  parameter int N      = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_result,
  input  logic              in_cout,
  input  logic [1:0]        in_select,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_result,
  output logic [1:0]        out_select,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_carry,
`ifdef ALU_RESULT_PARITY_EN
  output logic              out_parity,
`endif
  output logic              op_err,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [1:0] SEL_SHIFT  = 2'd2;
  localparam logic [1:0] SEL_UNUSED = 2'd3;

  logic [N-1:0] mem_result [2];
  logic [1:0]   mem_select [2];
  logic         mem_zero   [2];
  logic         mem_neg    [2];
  logic         mem_carry  [2];
`ifdef ALU_RESULT_PARITY_EN
  logic         mem_parity [2];
`endif

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       accept;
  logic       drop;
  logic       push;
  logic       pop;

  // Ready depends only on registered occupancy, so it never combinationally follows out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign drop      = accept && (in_select == SEL_UNUSED);
  assign push      = accept && !drop;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Flags are frozen at capture so the entry stays self-describing while it waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_result[i] <= '0;
        mem_select[i] <= 2'd0;
        mem_zero[i]   <= 1'b0;
        mem_neg[i]    <= 1'b0;
        mem_carry[i]  <= 1'b0;
`ifdef ALU_RESULT_PARITY_EN
        mem_parity[i] <= 1'b0;
`endif
      end
    end else if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_select[wr_ptr] <= in_select;
      mem_zero[wr_ptr]   <= (in_result == '0);
      mem_neg[wr_ptr]    <= in_result[N-1];
      mem_carry[wr_ptr]  <= (in_select == SEL_SHIFT) ? 1'b0 : in_cout;
`ifdef ALU_RESULT_PARITY_EN
      mem_parity[wr_ptr] <= ^in_result;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_err     <= 1'b0;
      drop_count <= '0;
    end else begin
      op_err <= drop;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  // Outputs read as zero whenever the FIFO is empty.
  assign out_result = out_valid ? mem_result[rd_ptr] : '0;
  assign out_select = out_valid ? mem_select[rd_ptr] : 2'd0;
  assign out_zero   = out_valid ? mem_zero[rd_ptr]   : 1'b0;
  assign out_neg    = out_valid ? mem_neg[rd_ptr]    : 1'b0;
  assign out_carry  = out_valid ? mem_carry[rd_ptr]  : 1'b0;
`ifdef ALU_RESULT_PARITY_EN
  assign out_parity = out_valid ? mem_parity[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: scoreboard queue of expected entries,
// directed steps plus a short random burst; parity checks when ALU_RESULT_PARITY_EN is defined.
module tb_alu_result_stage;

  localparam int N      = 4;
  localparam int DROP_W = 8;

  typedef struct {
    logic [N-1:0] result;
    logic [1:0]   select;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         parity;
  } exp_entry_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N-1:0]      in_result = '0;
  logic              in_cout = 1'b0;
  logic [1:0]        in_select = 2'd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N-1:0]      out_result;
  logic [1:0]        out_select;
  logic              out_zero;
  logic              out_neg;
  logic              out_carry;
  logic              op_err;
  logic [DROP_W-1:0] drop_count;
`ifdef ALU_RESULT_PARITY_EN
  logic              out_parity;
`endif

  exp_entry_t        sb[$];
  logic              exp_op_err = 1'b0;
  logic [DROP_W-1:0] exp_drop = '0;
  int                vectors = 0;
  int                miscompares = 0;

  alu_result_stage #(.N(N), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_cout    (in_cout),
    .in_select  (in_select),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_select (out_select),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_carry  (out_carry),
`ifdef ALU_RESULT_PARITY_EN
    .out_parity (out_parity),
`endif
    .op_err     (op_err),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every DUT output against the model state for the current cycle.
  task automatic checkOutput();
    check("in_ready", {31'd0, in_ready}, {31'd0, sb.size() != 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    check("op_err", {31'd0, op_err}, {31'd0, exp_op_err});
    check("drop_count", {24'd0, drop_count}, {24'd0, exp_drop});
    if (sb.size() != 0) begin
      check("out_result", {28'd0, out_result}, {28'd0, sb[0].result});
      check("out_select", {30'd0, out_select}, {30'd0, sb[0].select});
      check("out_zero", {31'd0, out_zero}, {31'd0, sb[0].zero});
      check("out_neg", {31'd0, out_neg}, {31'd0, sb[0].neg});
      check("out_carry", {31'd0, out_carry}, {31'd0, sb[0].carry});
`ifdef ALU_RESULT_PARITY_EN
      check("out_parity", {31'd0, out_parity}, {31'd0, sb[0].parity});
`endif
    end else begin
      check("out_result_empty", {28'd0, out_result}, 32'd0);
      check("out_flags_empty", {29'd0, out_zero, out_neg, out_carry}, 32'd0);
`ifdef ALU_RESULT_PARITY_EN
      check("out_parity_empty", {31'd0, out_parity}, 32'd0);
`endif
    end
  endtask

  // Drives one cycle of inputs from the low clock phase, checks, updates the model, advances.
  task automatic applyStimulus(input logic v, input logic [N-1:0] r, input logic c,
                               input logic [1:0] s, input logic ordy);
    exp_entry_t e;
    logic acc;
    logic pop;
    in_valid  = v;
    in_result = r;
    in_cout   = c;
    in_select = s;
    out_ready = ordy;
    #1;
    checkOutput();
    acc = v && (sb.size() != 2);
    pop = ordy && (sb.size() != 0);
    if (pop) void'(sb.pop_front());
    if (acc && s != 2'd3) begin
      e.result = r;
      e.select = s;
      e.zero   = (r == 4'd0);
      e.neg    = r[3];
      e.carry  = (s == 2'd2) ? 1'b0 : c;
      e.parity = r[0] ^ r[1] ^ r[2] ^ r[3];
      sb.push_back(e);
    end
    exp_op_err = acc && (s == 2'd3);
    if (exp_op_err && exp_drop != 8'd255) exp_drop = exp_drop + 8'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");
    #1;
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single zero result with carry, consumer always ready.
    applyStimulus(1'b1, 4'b0000, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);

    // Fill while stalled, third beat held off, then drain in order.
    applyStimulus(1'b1, 4'h9, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 4'h5, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 4'h5, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 4'h5, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b1, 4'h5, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);

    // Simultaneous push and pop at count 1.
    applyStimulus(1'b1, 4'h2, 1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, 4'h7, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);

    // Random traffic including stalls and unused selects.
    for (int i = 0; i < 60; i++)
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);

    // 260 unused-select beats with X data; counter must stop at 255.
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 4'bxxxx, 1'bx, 2'd3, 1'b1);
      applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
    end
    check("drop_saturated", {24'd0, drop_count}, 32'd255);

    // Fill, then assert reset asynchronously during the low phase.
    applyStimulus(1'b1, 4'hA, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b1, 4'hC, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    sb.delete();
    exp_op_err = 1'b0;
    exp_drop   = '0;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_drop", {24'd0, drop_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);

    // Parity-sensitive patterns (flag also checked through the model when enabled).
    applyStimulus(1'b1, 4'b1011, 1'b0, 2'd0, 1'b1);
`ifdef ALU_RESULT_PARITY_EN
    check("parity_1011", {31'd0, out_parity}, 32'd1);
`endif
    applyStimulus(1'b1, 4'b0110, 1'b0, 2'd2, 1'b1);
`ifdef ALU_RESULT_PARITY_EN
    check("parity_0110", {31'd0, out_parity}, 32'd0);
`endif
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
